reg_wb_arbiter: RTL and testbench

Write-back arbiter that shares a single register-file write port among the execution units (mov, alu, jump, fpu, imm). Each unit pushes (address, data) write requests through a valid/ready handshake into its own small FIFO. A round-robin scheduler drains the FIFOs onto one registered write port (`wr_start`/`wr_search`/`wr_in`). The block sits between the execution units and `reg_file`. It lets the file shrink from five write ports to one without dropping results.

---
 rtl/reg_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//
// Shares one register-file write port among N_REQ execution units
// (0=mov, 1=alu, 2=jump, 3=fpu, 4=imm). Each unit pushes {address, data}
// through a valid/ready handshake into a private FIFO. A round-robin
// scheduler pops at most one entry per cycle onto a registered write port.
//
// Parameters:
//   N_REQ       number of requesters (at most 8, because wr_src is 3 bits)
//   DW          write data width
//   AW          register address width
//   FIFO_DEPTH  entries per requester FIFO (power of two, >= 2)
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-low
//   req_valid[i]     requester i presents an entry
//   req_ready[i]     FIFO i has room (depends on occupancy only)
//   req_search_flat  target register, requester i at [i*AW +: AW]
//   req_in_flat      write data, requester i at [i*DW +: DW]
//   hold             blocks grants at the current edge
//   wr_start         one-cycle write-enable pulse per granted entry
//   wr_search/wr_in  write address / data (hold when there is no grant)
//   wr_src           requester that owns the current write
//   pending          any FIFO non-empty, or a write pulse is in flight
//
// Build option:
//   REG_WB_R0_DROP_EN  when defined, granted entries that target address 0
//                      are consumed without raising wr_start.
// ---------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int N_REQ      = 5,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*AW-1:0]   req_search_flat,
    input  logic [N_REQ*DW-1:0]   req_in_flat,
    input  logic                  hold,
    output logic                  wr_start,
    output logic [AW-1:0]         wr_search,
    output logic [DW-1:0]         wr_in,
    output logic [2:0]            wr_src,
    output logic                  pending
);

    localparam int EW = AW + DW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [N_REQ-1:0] not_empty;
    logic [N_REQ-1:0] pop;
    logic [EW-1:0]    fifo_head [N_REQ];
    logic [2:0]       rr_reg;
    logic             grant;
    logic [2:0]       winner;
    logic [EW-1:0]    head_entry;
    logic [AW-1:0]    head_addr;
    logic             wr_enable;

    // Per-requester FIFOs. Pointers wrap naturally because the depth is a
    // power of two; occupancy is a separate counter so full and empty are
    // distinguishable without a spare slot.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_fifo
            logic [EW-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          push;

            assign req_ready[gi] = (count_reg < CW'(FIFO_DEPTH));
            assign not_empty[gi] = (count_reg != '0);
            assign push          = req_valid[gi] && req_ready[gi];
            assign fifo_head[gi] = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= {req_search_flat[gi*AW +: AW],
                                        req_in_flat[gi*DW +: DW]};
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    if (push && !pop[gi]) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (!push && pop[gi]) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end
        end
    endgenerate

    // Round-robin scan starting at rr_reg; the first non-empty FIFO wins.
    always_comb begin
        int idx;
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant && !hold && not_empty[idx]) begin
                grant  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
    end

    assign head_entry = fifo_head[winner];
    assign head_addr  = head_entry[EW-1:DW];

`ifdef REG_WB_R0_DROP_EN
    // r0 is hardwired: consume the entry but suppress the write pulse.
    assign wr_enable = (head_addr != '0);
`else
    assign wr_enable = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg    <= '0;
            wr_start  <= 1'b0;
            wr_search <= '0;
            wr_in     <= '0;
            wr_src    <= '0;
        end else if (grant) begin
            wr_start  <= wr_enable;
            wr_search <= head_addr;
            wr_in     <= head_entry[DW-1:0];
            wr_src    <= winner;
            rr_reg    <= (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
        end else begin
            wr_start  <= 1'b0;
        end
    end

    assign pending = (|not_empty) | wr_start;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Directed stimulus against reg_wb_arbiter. A queue-based reference model
// tracks per-requester FIFO contents and the round-robin pointer; a compare
// process checks every DUT output against it on each falling edge, and the
// stimulus adds hand-computed literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_reg_wb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;

    typedef logic [AW+DW-1:0] ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_search_flat;
    logic [N*DW-1:0]   req_in_flat;
    logic              hold;
    logic              wr_start;
    logic [AW-1:0]     wr_search;
    logic [DW-1:0]     wr_in;
    logic [2:0]        wr_src;
    logic              pending;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .FIFO_DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_search_flat (req_search_flat),
        .req_in_flat     (req_in_flat),
        .hold            (hold),
        .wr_start        (wr_start),
        .wr_search       (wr_search),
        .wr_in           (wr_in),
        .wr_src          (wr_src),
        .pending         (pending)
    );

    // ---------------- reference model ----------------
    ent_t        q [N][$];
    int          m_rr = 0;
    logic        m_start = 1'b0;
    logic [AW-1:0] m_search = '0;
    logic [DW-1:0] m_in = '0;
    logic [2:0]  m_src = '0;

    always @(posedge clk) begin
        int   w;
        int   idx;
        bit [N-1:0] rdy;
        ent_t e;
        if (!reset) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_rr = 0; m_start = 1'b0; m_search = '0; m_in = '0; m_src = '0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = (q[i].size() < D);
            w = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (w < 0 && q[idx].size() > 0) w = idx;
                end
            end
            if (w >= 0) begin
                e        = q[w].pop_front();
                m_search = e[AW+DW-1:DW];
                m_in     = e[DW-1:0];
                m_src    = 3'(w);
                m_rr     = (w + 1) % N;
`ifdef REG_WB_R0_DROP_EN
                m_start  = (m_search != '0);
`else
                m_start  = 1'b1;
`endif
            end else begin
                m_start = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i])
                    q[i].push_back({req_search_flat[i*AW +: AW], req_in_flat[i*DW +: DW]});
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] m_rdy;
        bit           any;
        if (chk_en) begin
            any = m_start;
            for (int i = 0; i < N; i++) begin
                m_rdy[i] = (q[i].size() < D);
                if (q[i].size() > 0) any = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(m_rdy));
            check("wr_start",  64'(wr_start),  64'(m_start));
            check("wr_search", 64'(wr_search), 64'(m_search));
            check("wr_in",     64'(wr_in),     64'(m_in));
            check("wr_src",    64'(wr_src),    64'(m_src));
            check("pending",   64'(pending),   64'(any));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_search_flat[i*AW +: AW] = a;
        req_in_flat[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; req_valid = '0;
        req_search_flat = '0; req_in_flat = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_wr_start",  64'(wr_start),  64'd0);
        check("rst_wr_search", 64'(wr_search), 64'd0);
        check("rst_wr_in",     64'(wr_in),     64'd0);
        check("rst_wr_src",    64'(wr_src),    64'd0);
        check("rst_pending",   64'(pending),   64'd0);
        check("rst_ready",     64'(req_ready), 64'h1f);
        reset = 1'b1;

        // Single write: push at edge 1, grant at edge 2.
        drive(1, 5'd7, 32'hDEADBEEF);
        step();
        idle();
        step();
        check("single_start",  64'(wr_start),  64'd1);
        check("single_search", 64'(wr_search), 64'd7);
        check("single_in",     64'(wr_in),     64'hDEADBEEF);
        check("single_src",    64'(wr_src),    64'd1);
        check("single_rr",     64'(m_rr),      64'd2);
        step();
        check("single_done",   64'(pending),   64'd0);

        // Full contention from rr=0.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 5'(10 + i), 32'(32'h100 + i));
        step();
        idle();
        for (int c = 0; c < N; c++) begin
            step();
            check("cont_start", 64'(wr_start), 64'd1);
            check("cont_src",   64'(wr_src),   64'(c));
            check("cont_data",  64'(wr_in),    64'(32'h100 + c));
        end
        step();
        check("cont_pending_drop", 64'(pending), 64'd0);

        // Backpressure on requester 3 while held.
        hold = 1'b1;
        drive(3, 5'd3, 32'hA0); step();
        check("bp_ready_1", 64'(req_ready[3]), 64'd1);
        drive(3, 5'd3, 32'hA1); step();
        check("bp_ready_2", 64'(req_ready[3]), 64'd0);
        drive(3, 5'd3, 32'hA2); step();
        check("bp_ready_3", 64'(req_ready[3]), 64'd0);
        check("bp_held",    64'(wr_start),     64'd0);
        idle(); hold = 1'b0;
        step();
        check("bp_first",   64'(wr_in),        64'hA0);
        check("bp_reready", 64'(req_ready[3]), 64'd1);
        step();
        check("bp_second",  64'(wr_in),        64'hA1);
        step();
        check("bp_end",     64'(wr_start),     64'd0);

        // Wrap: rr is now 4, FIFOs 0 and 4 loaded together.
        drive(0, 5'd20, 32'h00); drive(4, 5'd24, 32'h44);
        step();
        idle();
        step();
        check("wrap_first",  64'(wr_src), 64'd4);
        step();
        check("wrap_second", 64'(wr_src), 64'd0);
        step();

        // Reset while FIFOs hold data and a write is in flight.
        drive(0, 5'd1, 32'h11); drive(1, 5'd2, 32'h22); drive(2, 5'd3, 32'h33);
        step();
        drive(0, 5'd4, 32'h44);
        step();
        idle();
        check("mid_inflight", 64'(wr_start), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_start",   64'(wr_start),  64'd0);
        check("mid_search",  64'(wr_search), 64'd0);
        check("mid_in",      64'(wr_in),     64'd0);
        check("mid_src",     64'(wr_src),    64'd0);
        check("mid_pending", 64'(pending),   64'd0);
        check("mid_ready",   64'(req_ready), 64'h1f);
        for (int c = 0; c < 4; c++) begin
            step();
            check("mid_quiet", 64'(wr_start), 64'd0);
        end

        // Address-0 entry.
        drive(2, 5'd0, 32'h1234);
        step();
        idle();
        step();
`ifdef REG_WB_R0_DROP_EN
        check("r0_start",   64'(wr_start), 64'd0);
        check("r0_pending", 64'(pending),  64'd0);
`else
        check("r0_start",   64'(wr_start),  64'd1);
        check("r0_search",  64'(wr_search), 64'd0);
        check("r0_in",      64'(wr_in),     64'h1234);
`endif
        step();

        // Mixed traffic with occasional hold; checked by the compare process.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                if (((c * 7 + i * 3) % 5) < 2)
                    drive(i, 5'((c + i) % 32), 32'(c * 256 + i));
                else
                    req_valid[i] = 1'b0;
            end
            hold = ((c % 9) == 4);
            step();
        end
        idle(); hold = 1'b0;
        repeat (12) step();
        check("drain_pending", 64'(pending), 64'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
